// File: rtl/zeroheti_irq_cond.sv
// Per-line interrupt conditioner: synchroniser, stability filter, level/edge output stage.
// Optional glitch statistics counter enabled by defining ZEROHETI_IRQ_COND_STATS_EN.
//
// state | meaning
// LOW   | filtered level 0, synchronised input low
// RISE  | filtered level 0, counting a candidate rise
// HIGH  | filtered level 1, synchronised input high
// FALL  | filtered level 1, counting a candidate fall
module zeroheti_irq_cond #(
  parameter int NrIrqs     = 32,
  parameter int SyncStages = 2,
  parameter int FiltWidth  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NrIrqs-1:0]    irqs_i,
  input  logic [NrIrqs-1:0]    edge_mask_i,
  input  logic [FiltWidth-1:0] filt_len_i,
`ifdef ZEROHETI_IRQ_COND_STATS_EN
  input  logic                 glitch_clr_i,
  output logic [15:0]          glitch_cnt_o,
`endif
  output logic [NrIrqs-1:0]    irqs_o
);

  typedef enum logic [1:0] {ST_LOW, ST_RISE, ST_HIGH, ST_FALL} state_e;

  logic [NrIrqs-1:0]    sync_q [SyncStages];
  logic [NrIrqs-1:0]    s;
  state_e               state_q [NrIrqs];
  state_e               state_d [NrIrqs];
  logic [FiltWidth-1:0] cnt_q   [NrIrqs];
  logic [FiltWidth-1:0] cnt_d   [NrIrqs];
  logic [NrIrqs-1:0]    abort;
  logic [NrIrqs-1:0]    rise_evt;
  logic [NrIrqs-1:0]    f_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < SyncStages; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= irqs_i;
      for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SyncStages-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrIrqs; i++) begin
        state_q[i] <= ST_LOW;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NrIrqs; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NrIrqs; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      abort[i]    = 1'b0;
      rise_evt[i] = 1'b0;
      case (state_q[i])
        ST_LOW: if (s[i]) begin
          if (filt_len_i == '0) begin
            state_d[i]  = ST_HIGH;
            rise_evt[i] = 1'b1;
          end else begin
            state_d[i] = ST_RISE;
            cnt_d[i]   = FiltWidth'(1);
          end
        end
        ST_RISE: if (!s[i]) begin
          state_d[i] = ST_LOW;
          cnt_d[i]   = '0;
          abort[i]   = 1'b1;
        end else if (cnt_q[i] >= filt_len_i) begin
          state_d[i]  = ST_HIGH;
          cnt_d[i]    = '0;
          rise_evt[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + FiltWidth'(1);
        end
        ST_HIGH: if (!s[i]) begin
          if (filt_len_i == '0) begin
            state_d[i] = ST_LOW;
          end else begin
            state_d[i] = ST_FALL;
            cnt_d[i]   = FiltWidth'(1);
          end
        end
        ST_FALL: if (s[i]) begin
          state_d[i] = ST_HIGH;
          cnt_d[i]   = '0;
          abort[i]   = 1'b1;
        end else if (cnt_q[i] >= filt_len_i) begin
          state_d[i] = ST_LOW;
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + FiltWidth'(1);
        end
        default: begin
          state_d[i] = ST_LOW;
          cnt_d[i]   = '0;
        end
      endcase
      f_d[i] = (state_d[i] == ST_HIGH) || (state_d[i] == ST_FALL);
    end
  end

  // Output reflects the filter state being entered, so it is valid the first cycle f is 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irqs_o <= '0;
    else       irqs_o <= (edge_mask_i & rise_evt) | (~edge_mask_i & f_d);
  end

`ifdef ZEROHETI_IRQ_COND_STATS_EN
  logic [16:0] pop;
  logic [16:0] sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NrIrqs; i++) pop = pop + 17'(abort[i]);
    sum = {1'b0, glitch_cnt_o} + pop;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             glitch_cnt_o <= '0;
    else if (glitch_clr_i) glitch_cnt_o <= '0;
    else if (sum[16])      glitch_cnt_o <= 16'hFFFF;
    else                   glitch_cnt_o <= sum[15:0];
  end
`endif

endmodule

// File: tb/tb_zeroheti_irq_cond.sv
// Self-checking bench for zeroheti_irq_cond: run-length reference model plus directed literal checks.
module tb_zeroheti_irq_cond;
  localparam int NR = 32;
  localparam int SS = 2;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] irqs = '0;
  logic [NR-1:0] em = '0;
  logic [FW-1:0] n = 4'd3;
  logic [NR-1:0] irqs_o;
`ifdef ZEROHETI_IRQ_COND_STATS_EN
  logic          clr = 1'b0;
  logic [15:0]   gcnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  zeroheti_irq_cond #(.NrIrqs(NR), .SyncStages(SS), .FiltWidth(FW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .irqs_i      (irqs),
    .edge_mask_i (em),
    .filt_len_i  (n),
`ifdef ZEROHETI_IRQ_COND_STATS_EN
    .glitch_clr_i(clr),
    .glitch_cnt_o(gcnt),
`endif
    .irqs_o      (irqs_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a line's filtered level flips once the synchronised input has
  // disagreed with it for N+1 consecutive cycles; a disagreement run that ends early is a glitch.
  logic [NR-1:0] pipe [SS];
  logic [NR-1:0] mf = '0;
  logic [NR-1:0] ms;
  logic [NR-1:0] rose;
  logic [NR-1:0] exp_o = '0;
  int            run [NR];
  int            ab;
  int            mgc = 0;

  initial begin
    for (int k = 0; k < SS; k++) pipe[k] = '0;
    for (int i = 0; i < NR; i++) run[i] = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < SS; k++) pipe[k] = '0;
        for (int i = 0; i < NR; i++) run[i] = 0;
        mf = '0; exp_o = '0; mgc = 0;
      end else begin
        ms = pipe[SS-1];
        ab = 0;
        rose = '0;
        for (int i = 0; i < NR; i++) begin
          if (ms[i] != mf[i]) begin
            run[i]++;
            if (run[i] >= int'(n) + 1) begin
              mf[i]   = ~mf[i];
              rose[i] = mf[i];
              run[i]  = 0;
            end
          end else begin
            if (run[i] > 0) ab++;
            run[i] = 0;
          end
        end
        exp_o = (em & rose) | (~em & mf);
`ifdef ZEROHETI_IRQ_COND_STATS_EN
        if (clr) mgc = 0;
        else     mgc = (mgc + ab > 65535) ? 65535 : mgc + ab;
`endif
        for (int k = SS - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = irqs;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_irqs_o", irqs_o, exp_o);
`ifdef ZEROHETI_IRQ_COND_STATS_EN
    chk("model_glitch_cnt", {16'h0, gcnt}, mgc);
`endif
  end

  int guard;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_irqs_o", irqs_o, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Level line 0 and edge line 1, N=3.
    em = 32'h2; n = 4'd3;
    @(posedge clk); #1 irqs[1:0] = 2'b11;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("lvl_line0", {31'h0, irqs_o[0]}, (c >= 7) ? 32'h1 : 32'h0);
      chk("edge_line1", {31'h0, irqs_o[1]}, (c == 7) ? 32'h1 : 32'h0);
      if (c == 10) irqs[1] = 1'b0;
    end
    irqs = '0;
    repeat (10) @(negedge clk);

    // 3-cycle glitch on level line 2.
    em = '0;
    irqs[2] = 1'b1;
    repeat (3) @(negedge clk);
    irqs[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("glitch_line2", {31'h0, irqs_o[2]}, 32'h0);
    end
`ifdef ZEROHETI_IRQ_COND_STATS_EN
    chk("glitch_cnt_one", {16'h0, gcnt}, 32'h1);
    clr = 1'b1;
    irqs[3:0] = 4'hF;
    @(negedge clk);
    irqs[3:0] = 4'h0;
    repeat (5) @(negedge clk);
    chk("glitch_clr_prio", {16'h0, gcnt}, 32'h0);
    clr = 1'b0;
`endif

    // N=0: all lines rise together.
    n = 4'd0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1 irqs = '1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("n0_all_lines", irqs_o, (c >= 4) ? 32'hFFFF_FFFF : 32'h0);
    end
    irqs = '0;
    repeat (6) @(negedge clk);

    // N=15: 15-cycle run rejected on line 7, 16-cycle run accepted on line 8.
    n = 4'd15;
    repeat (4) @(negedge clk);
    @(posedge clk); #1 irqs[8:7] = 2'b11;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      chk("n15_short_line7", {31'h0, irqs_o[7]}, 32'h0);
      chk("n15_full_line8", {31'h0, irqs_o[8]}, (c >= 19) ? 32'h1 : 32'h0);
      if (c == 16) irqs[7] = 1'b0;
    end
    irqs = '0;
    repeat (20) @(negedge clk);

    // Async reset mid-RISE, then inputs held high across release.
    n = 4'd3;
    irqs[6] = 1'b1;
    repeat (10) @(negedge clk);
    chk("line6_high", {31'h0, irqs_o[6]}, 32'h1);
    irqs[0] = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", irqs_o, 32'h0);
    irqs[5] = 1'b1; em = 32'h20; n = 4'd1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("rst_edge_line5", {31'h0, irqs_o[5]}, (k == 4) ? 32'h1 : 32'h0);
      chk("rst_lvl_line0", {31'h0, irqs_o[0]}, (k >= 4) ? 32'h1 : 32'h0);
    end
    // A level line switched to edge mode while high must stay 0.
    em[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("lvl_to_edge_line0", {31'h0, irqs_o[0]}, 32'h0);

    // Randomized traffic, several filter lengths, occasional mid-run N and mode changes.
    for (int seg = 0; seg < 6; seg++) begin
      n  = 4'($urandom_range(0, 15));
      em = $urandom;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        irqs = irqs ^ ($urandom & $urandom & $urandom);
        if ($urandom_range(0, 63) == 0) n = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 99) == 0) em = $urandom;
      end
    end

`ifdef ZEROHETI_IRQ_COND_STATS_EN
    // Drive the glitch counter to FFFE, then saturate it with four simultaneous glitches.
    irqs = '0; em = '0; n = 4'd1;
    repeat (20) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    guard = 0;
    while (mgc < 65000 && guard < 10000) begin
      @(negedge clk);
      irqs = ~irqs;
      guard++;
    end
    irqs = '0;
    repeat (6) @(negedge clk);
    guard = 0;
    while (mgc < 65534 && guard < 2000) begin
      irqs[0] = 1'b1;
      @(negedge clk);
      irqs[0] = 1'b0;
      repeat (5) @(negedge clk);
      guard++;
    end
    chk("glitch_preset", {16'h0, gcnt}, 32'hFFFE);
    irqs[3:0] = 4'hF;
    @(negedge clk);
    irqs[3:0] = 4'h0;
    repeat (5) @(negedge clk);
    chk("glitch_saturate", {16'h0, gcnt}, 32'hFFFF);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/zeroheti_irq_cond.md
Name: zeroheti_irq_cond

Overview:
- Per-line interrupt input conditioner, directly upstream of zeroheti_int_ctrl; irqs_o drives its ext_irqs_i.
- Each line is synchronised into clk_i, debounced by a programmable stability filter, then presented as a level or a single-cycle rising-edge pulse.
- Keeps metastability and glitch handling out of the arbitration logic, so the controller sees only clean, synchronous requests.

Parameters:
- NrIrqs, 32, number of interrupt lines; matches the controller's num_irqs.
- SyncStages, 2, flip-flop depth of each input synchroniser; minimum 2.
- FiltWidth, 4, width of filt_len_i and of each per-line filter counter.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  asynchronous, active-high reset.
- irqs_i  in  NrIrqs  raw asynchronous interrupt lines.
- edge_mask_i  in  NrIrqs  per line: 1 = rising-edge pulse output, 0 = level output; quasi-static.
- filt_len_i  in  FiltWidth  global debounce length N; quasi-static.
- irqs_o  out  NrIrqs  conditioned requests to zeroheti_int_ctrl.ext_irqs_i; registered.

Behaviour:
- Reset: all synchroniser FFs 0, every line FSM in LOW, counters 0, filtered levels 0, irqs_o 0.
- Synchroniser: s[i] is irqs_i[i] delayed by SyncStages clk_i edges. No other logic uses irqs_i directly.
- Per-line FSM (states LOW, RISE, HIGH, FALL) with counter cnt[FiltWidth-1:0]:
  - LOW, s=1: if N=0, go to HIGH; else cnt<=1 and go to RISE.
  - RISE, s=0: go to LOW, cnt<=0; this is an aborted rise (glitch).
  - RISE, s=1: if cnt>=N, go to HIGH and cnt<=0; else cnt<=cnt+1.
  - HIGH and FALL mirror LOW and RISE with the polarity inverted. An aborted fall returns to HIGH.
  - Filtered level f[i] = 1 in HIGH and FALL; f[i] = 0 in LOW and RISE.
- Qualification: s must hold the new level for N+1 consecutive cycles. f changes on the edge ending the last qualifying cycle.
- Total latency from an irqs_i change to irqs_o: SyncStages+N+1 cycles.
- Comparison uses >=. If N is lowered mid-count, a counter already at or above the new N qualifies on the next cycle. Counters never wrap.
- N = 2^FiltWidth-1 is legal; a qualifying run is then 2^FiltWidth cycles.
- Level lines (edge_mask_i[i]=0): irqs_o[i] = f[i], registered.
- Edge lines (edge_mask_i[i]=1):
  - irqs_o[i] is 1 for exactly one cycle: the first cycle f[i] is 1 after a RISE-to-HIGH or LOW-to-HIGH transition.
  - The FALL state and falling edges produce no pulse.
  - An aborted fall (FALL back to HIGH) produces no new pulse.
- edge_mask_i change: takes effect on the next registered output and never generates a pulse by itself. A level line switched to edge mode while HIGH drives 0 until its next qualified rise.
- Lines are fully independent. Simultaneous events on any number of lines are handled in the same cycle.
- Inputs held high across reset release are treated as rising from 0: normal qualification, and one pulse on edge lines.
- Asserting rst_i mid-operation returns every line to LOW immediately (asynchronous). Pending qualification is lost.

Optional Feature:
- Macro: ZEROHETI_IRQ_COND_STATS_EN.
- With the macro, two extra ports are present:
  - glitch_clr_i  in  1  synchronous clear of the glitch counter.
  - glitch_cnt_o  out  16  count of aborted rises and falls.
- Counter behaviour:
  - Each cycle, the counter adds the number of lines aborting RISE or FALL that cycle (popcount).
  - The counter saturates at 16'hFFFF.
  - glitch_clr_i has priority: the counter becomes 0 even if aborts occur in the same cycle.
  - Reset value is 0.
- Without the macro, neither port exists and there is no counter logic.

Test Plan:
- SyncStages=2, N=3, line 0 level mode; irqs_i[0] rises after the edge ending cycle 0 and is held -> irqs_o[0]=0 through cycle 6, =1 from cycle 7.
- N=3, line 1 edge mode; irqs_i[1] is high for 10 cycles, then low -> irqs_o[1] is 1 for exactly one cycle (cycle 7), and there is no pulse on the fall.
- N=3, line 2 level mode; 3-cycle high glitch on irqs_i[2] -> irqs_o[2] stays 0, and glitch_cnt_o=1 (STATS_EN).
- N=0, all 32 lines rise together in level mode -> all irqs_o bits are 1 simultaneously, SyncStages+1 cycles later.
- Lines 0-3 glitch in the same cycle while glitch_clr_i=1 -> glitch_cnt_o=0. Preset the counter to 16'hFFFE, then 4 glitches -> glitch_cnt_o=16'hFFFF.
- irqs_i[5] high across rst_i deassertion, edge mode, N=1 -> one pulse exactly SyncStages+2 cycles after reset release. rst_i asserted mid-RISE -> irqs_o=0 asynchronously, and qualification restarts from 0.
